prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
// - Writer side of the instruction-memory interface: accepts a stream of 9-bit instruction words and writes them
//   into instruction memory from address 0 upward. The fetch unit is the reader side of the same memory.
// - After the last word it pulses the core's start for START_CYCLES cycles and counts run cycles until halt.
// - Sits between the testbench/host stream and top_level.
// PARAMETERS
// - INSTR_WIDTH   9    instruction word width; matches the core.
// - ADDR_WIDTH    10   instruction memory address width; depth is 2**ADDR_WIDTH.
// - START_CYCLES  2    number of cycles start is held high; must be >= 1.
// - CNT_WIDTH     16   width of run_cycles.
// PORTS
// - clk           in   1            rising-edge clock
// - rst_n         in   1            asynchronous reset, active-low
// - load_req      in   1            request a new load; sampled only in IDLE, DONE and ERR
// - in_valid      in   1            stream word valid
// - in_data       in   INSTR_WIDTH  stream word
// - in_last       in   1            marks the final word of the program
// - in_ready      out  1            loader can accept a word
// - imem_we       out  1            instruction memory write enable
// - imem_waddr    out  ADDR_WIDTH   instruction memory write address
// - imem_wdata    out  INSTR_WIDTH  instruction memory write data
// - start         out  1            core start/initialise strobe
// - halt          in   1            core halt flag
// - busy          out  1            high in LOAD, START and RUN
// - done          out  1            program halted; sticky until the next load
// - err_overflow  out  1            program too long; sticky until the next load
// - prog_len      out  ADDR_WIDTH+1 number of words written
// - run_cycles    out  CNT_WIDTH    clock cycles from start deassertion to halt; saturates at all-ones
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE. Every output is 0, including imem_*, prog_len and run_cycles.
// - States: IDLE, LOAD, START, RUN, DONE, ERR.
// - IDLE/DONE/ERR, load_req=1 -> LOAD next cycle.
//   - On that same edge: clear prog_len, run_cycles, done and err_overflow, and set the write pointer to 0.
// - In these three states in_ready=0. A beat presented in the same cycle as load_req is not accepted.
// - LOAD: in_ready=1. A beat is accepted when in_valid && in_ready.
//   - Write latency: imem_we=1 for exactly one cycle, on the cycle after acceptance.
//   - imem_waddr = pointer value at acceptance; imem_wdata = the registered word.
//   - prog_len and the pointer increment on the acceptance edge.
// - Accepted beat with in_last=1 -> START. in_ready drops in the following cycle.
// - Overflow: accepted beat at pointer 2**ADDR_WIDTH-1 with in_last=0.
//   - That word is still written; err_overflow=1; go to ERR. start is never asserted.
// - Overflow takes priority: the final address with in_last=1 is a legal full program -> START, no error.
// - The pointer never wraps.
// - START: start=1 for exactly START_CYCLES cycles -> RUN. halt is ignored during START.
//   - The last imem write always completes before start rises.
// - RUN: run_cycles increments every cycle while halt=0 and saturates at all-ones.
//   - Sampling halt=1 -> DONE with done=1; run_cycles freezes (it does not count that cycle).
// - load_req is ignored in LOAD, START and RUN.
// - Reset mid-operation aborts immediately: everything returns to reset values; partial memory contents are not erased.
// - imem_we, start, busy and done are driven from registers, with no combinational path from inputs.
//   - Exception: in_ready, which is a decode of the registered state only.
// STRUCTURE
// - Package loader_pkg: state enum loader_state_t {IDLE, LOAD, START, RUN, DONE, ERR} and default width localparams.
// - One sub-module: sat_counter, parameterised width, with clear/enable/saturate. Used for run_cycles.
// - The write pointer and the START_CYCLES timer stay inline in the FSM.
// TESTING
// 1. Reset mid-RUN -> all outputs 0 the same cycle; state IDLE; a following load_req is accepted normally.
// 2. load_req, then 4 back-to-back beats 0x1A0,0x055,0x0FF,0x100 with last on beat 4:
//    - imem writes at addresses 0..3 with that data, each one cycle after its beat.
//    - prog_len=4; start high 2 cycles.
// 3. Case 2 with in_valid toggling every other cycle:
//    - Same 4 writes, no gaps or duplicates; no write cycles while in_valid=0.
// 4. After start, hold halt=0 for 37 cycles, then halt=1:
//    - done=1; run_cycles=37; busy=0; a further load_req clears done and run_cycles.
// 5. ADDR_WIDTH=3, 8 beats with no last:
//    - Address 7 is written; err_overflow=1; start never rises.
//    - ADDR_WIDTH=3, 8 beats with last on beat 8: START reached, no error.
// 6. CNT_WIDTH=4, halt held low 40 cycles -> run_cycles saturates at 15. load_req during RUN -> no effect.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and default widths for the program loader.
package loader_pkg;

    localparam int unsigned DefInstrWidth  = 9;
    localparam int unsigned DefAddrWidth   = 10;
    localparam int unsigned DefStartCycles = 2;
    localparam int unsigned DefCntWidth    = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StDone,
        StErr
    } loader_state_t;

    // States in which the loader owns the core.
    function automatic logic is_busy(loader_state_t s);
        return (s == StLoad) || (s == StStart) || (s == StRun);
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Instruction stream (host -> loader) and instruction-memory write port (loader -> imem).
interface prog_loader_if #(
    parameter int unsigned INSTR_WIDTH = loader_pkg::DefInstrWidth,
    parameter int unsigned ADDR_WIDTH  = loader_pkg::DefAddrWidth
) ();

    logic                   in_valid;
    logic [INSTR_WIDTH-1:0] in_data;
    logic                   in_last;
    logic                   in_ready;
    logic                   imem_we;
    logic [ADDR_WIDTH-1:0]  imem_waddr;
    logic [INSTR_WIDTH-1:0] imem_wdata;

    // Host / testbench side.
    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, imem_we, imem_waddr, imem_wdata
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, imem_we, imem_waddr, imem_wdata
    );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Clear wins over enable; no increment once saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a program into instruction memory, strobes the core's start, then times the run.
module prog_loader
    import loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH  = DefInstrWidth,
    parameter int unsigned ADDR_WIDTH   = DefAddrWidth,
    parameter int unsigned START_CYCLES = DefStartCycles,
    parameter int unsigned CNT_WIDTH    = DefCntWidth
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_req_i,
    input  logic                  halt_i,
    prog_loader_if.slave          bus,
    output logic                  start_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_overflow_o,
    output logic [ADDR_WIDTH:0]   prog_len_o,
    output logic [CNT_WIDTH-1:0]  run_cycles_o
);

    // Timer counts 0..START_CYCLES: cycle 0 lets the last imem write land before start rises.
    localparam int unsigned TmrW = (START_CYCLES < 1) ? 1 : $clog2(START_CYCLES + 1);

    loader_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]    len_q, len_d;
    logic [TmrW-1:0]        tmr_q, tmr_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   start_q, start_d;
    logic                   busy_q, done_q, err_q;
    logic                   accept;
    logic                   cnt_clr, cnt_en;

    assign bus.in_ready = (state_q == StLoad);
    assign accept       = bus.in_valid && (state_q == StLoad);

    // Next-state, pointer, write-port and timer logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        tmr_d   = tmr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        start_d = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (load_req_i) begin
                    state_d = StLoad;
                    ptr_d   = '0;
                    len_d   = '0;
                    cnt_clr = 1'b1;
                end
            end
            StLoad: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = ptr_q;
                    wdata_d = bus.in_data;
                    len_d   = len_q + (ADDR_WIDTH + 1)'(1);
                    // Pointer holds at the top address rather than wrapping.
                    if (ptr_q != '1) begin
                        ptr_d = ptr_q + ADDR_WIDTH'(1);
                    end
                    if ((ptr_q == '1) && !bus.in_last) begin
                        state_d = StErr;
                    end else if (bus.in_last) begin
                        state_d = StStart;
                        tmr_d   = '0;
                    end
                end
            end
            StStart: begin
                if (tmr_q == TmrW'(START_CYCLES)) begin
                    state_d = StRun;
                end else begin
                    tmr_d   = tmr_q + TmrW'(1);
                    start_d = 1'b1;
                end
            end
            StRun: begin
                if (halt_i) begin
                    state_d = StDone;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            len_q   <= '0;
            tmr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            tmr_q   <= tmr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            start_q <= start_d;
            busy_q  <= is_busy(state_d);
            done_q  <= (state_d == StDone);
            err_q   <= (state_d == StErr);
        end
    end

    sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_run_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .cnt_o (run_cycles_o)
    );

    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign start_o        = start_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_overflow_o = err_q;
    assign prog_len_o     = len_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench: default-width loader (a) and a 3-bit-address / 4-bit-counter loader (b).
module tb_prog_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        load_req_a = 1'b0, halt_a = 1'b0, load_req_b = 1'b0, halt_b = 1'b0;
    logic        start_a, busy_a, done_a, err_a, start_b, busy_b, done_b, err_b;
    logic [10:0] len_a;
    logic [15:0] run_a;
    logic [3:0]  len_b;
    logic [3:0]  run_b;

    prog_loader_if #(.INSTR_WIDTH(9), .ADDR_WIDTH(10)) if_a ();
    prog_loader_if #(.INSTR_WIDTH(9), .ADDR_WIDTH(3))  if_b ();

    prog_loader u_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_req_i     (load_req_a),
        .halt_i         (halt_a),
        .bus            (if_a),
        .start_o        (start_a),
        .busy_o         (busy_a),
        .done_o         (done_a),
        .err_overflow_o (err_a),
        .prog_len_o     (len_a),
        .run_cycles_o   (run_a)
    );

    prog_loader #(
        .ADDR_WIDTH (3),
        .CNT_WIDTH  (4)
    ) u_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_req_i     (load_req_b),
        .halt_i         (halt_b),
        .bus            (if_b),
        .start_o        (start_b),
        .busy_o         (busy_b),
        .done_o         (done_b),
        .err_overflow_o (err_b),
        .prog_len_o     (len_b),
        .run_cycles_o   (run_b)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_hi_a = 0;
    int start_hi_b = 0;
    int acc_a[$];
    int wr_cyc_a[$];
    logic [9:0] wr_addr_a[$];
    logic [8:0] wr_data_a[$];
    logic [2:0] wr_addr_b[$];
    logic [8:0] words[8];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the stream and write port mid-cycle.
    always @(negedge clk) begin
        if (rst_n && if_a.in_valid && if_a.in_ready) acc_a.push_back(cyc);
        if (if_a.imem_we) begin
            wr_cyc_a.push_back(cyc);
            wr_addr_a.push_back(if_a.imem_waddr);
            wr_data_a.push_back(if_a.imem_wdata);
        end
        if (start_a) start_hi_a++;
        if (if_b.imem_we) wr_addr_b.push_back(if_b.imem_waddr);
        if (start_b) start_hi_b++;
    end

    initial begin
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_last = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_start_fall_a(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev = start_a;
            tick();
            if (prev && !start_a) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start_fall_b(output bit ok);
        logic prev;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            prev = start_b;
            tick();
            if (prev && !start_b) begin ok = 1'b1; break; end
        end
    endtask

    // First beat is already valid during the load_req cycle when not gapped.
    task automatic load_a(input int n, input bit gap);
        acc_a.delete(); wr_cyc_a.delete(); wr_addr_a.delete(); wr_data_a.delete();
        load_req_a = 1'b1;
        if_a.in_valid = !gap; if_a.in_data = words[0]; if_a.in_last = (n == 1);
        tick();
        load_req_a = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap) begin if_a.in_valid = 1'b0; tick(); end
            if_a.in_valid = 1'b1; if_a.in_data = words[i]; if_a.in_last = (i == n - 1);
            tick();
        end
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0;
    endtask

    task automatic load_b(input int n, input bit last_at_end);
        wr_addr_b.delete();
        load_req_b = 1'b1; if_b.in_valid = 1'b0;
        tick();
        load_req_b = 1'b0;
        for (int i = 0; i < n; i++) begin
            if_b.in_valid = 1'b1; if_b.in_data = words[i];
            if_b.in_last = last_at_end && (i == n - 1);
            tick();
        end
        if_b.in_valid = 1'b0; if_b.in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        checks++;
        if ({if_a.in_ready, if_a.imem_we, start_a, busy_a, done_a, err_a} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags_a: got %b want 000000",
                     {if_a.in_ready, if_a.imem_we, start_a, busy_a, done_a, err_a});
        end
        checks++;
        if ({if_a.imem_waddr, if_a.imem_wdata, len_a, run_a} !== 46'b0) begin
            errors++;
            $display("FAIL reset_values_a: waddr=%0h wdata=%0h len=%0d run=%0d want all 0",
                     if_a.imem_waddr, if_a.imem_wdata, len_a, run_a);
        end
        checks++;
        if ({if_b.in_ready, start_b, busy_b, done_b, err_b, len_b, run_b} !== 13'b0) begin
            errors++;
            $display("FAIL reset_b: got %b want 0",
                     {if_b.in_ready, start_b, busy_b, done_b, err_b, len_b, run_b});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_writes_a(input string name);
        checks++;
        if (wr_addr_a.size() !== 4 || acc_a.size() !== 4) begin
            errors++;
            $display("FAIL %s_count: writes=%0d accepts=%0d want 4/4", name, wr_addr_a.size(),
                     acc_a.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_a[i] !== 10'(i) || wr_data_a[i] !== words[i]
                    || wr_cyc_a[i] !== acc_a[i] + 1) begin
                    errors++;
                    $display("FAIL %s_write%0d: addr=%0d data=%h cyc=%0d want addr=%0d data=%h cyc=%0d",
                             name, i, wr_addr_a[i], wr_data_a[i], wr_cyc_a[i], i, words[i],
                             acc_a[i] + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        words[0] = 9'h1A0; words[1] = 9'h055; words[2] = 9'h0FF; words[3] = 9'h100;
        start_hi_a = 0;
        load_a(4, 1'b0);
        checks++;
        if ({if_a.imem_we, start_a, if_a.imem_waddr} !== {1'b1, 1'b0, 10'd3}) begin
            errors++;
            $display("FAIL b2b_last_write: we=%b start=%b addr=%0d want we=1 start=0 addr=3",
                     if_a.imem_we, start_a, if_a.imem_waddr);
        end
        checks++;
        if (len_a !== 11'd4) begin
            errors++; $display("FAIL b2b_prog_len: got %0d want 4", len_a);
        end
        wait_start_fall_a(ok);
        checks++;
        if (!ok || start_hi_a !== 2) begin
            errors++; $display("FAIL b2b_start: fell=%0b high=%0d want 1/2", ok, start_hi_a);
        end
        checks++;
        if (busy_a !== 1'b1) begin
            errors++; $display("FAIL b2b_busy_run: got %b want 1", busy_a);
        end
        check_writes_a("b2b");
    endtask

    task automatic test_run_count();
        bit ok;
        halt_a = 1'b0;
        repeat (37) tick();
        halt_a = 1'b1;
        tick();
        checks++;
        if ({done_a, busy_a, start_a} !== 3'b100 || run_a !== 16'd37) begin
            errors++;
            $display("FAIL run_halt: done=%b busy=%b start=%b run=%0d want 1/0/0/37",
                     done_a, busy_a, start_a, run_a);
        end
        load_req_a = 1'b1;
        tick();
        load_req_a = 1'b0;
        checks++;
        if ({done_a, busy_a, if_a.in_ready} !== 3'b011 || run_a !== 16'd0 || len_a !== 11'd0) begin
            errors++;
            $display("FAIL run_reload_clear: done=%b busy=%b rdy=%b run=%0d len=%0d want 0/1/1/0/0",
                     done_a, busy_a, if_a.in_ready, run_a, len_a);
        end
        // Single-word program with halt already high: halt must not cut START short.
        start_hi_a = 0;
        if_a.in_valid = 1'b1; if_a.in_data = 9'h0AB; if_a.in_last = 1'b1;
        tick();
        if_a.in_valid = 1'b0; if_a.in_last = 1'b0;
        checks++;
        if (len_a !== 11'd1) begin
            errors++; $display("FAIL one_word_len: got %0d want 1", len_a);
        end
        wait_start_fall_a(ok);
        checks++;
        if (!ok || start_hi_a !== 2) begin
            errors++; $display("FAIL halt_in_start: fell=%0b high=%0d want 1/2", ok, start_hi_a);
        end
        tick();
        checks++;
        if (done_a !== 1'b1 || run_a !== 16'd0) begin
            errors++; $display("FAIL immediate_halt: done=%b run=%0d want 1/0", done_a, run_a);
        end
        halt_a = 1'b0;
    endtask

    task automatic test_gapped();
        bit ok;
        words[0] = 9'h1A0; words[1] = 9'h055; words[2] = 9'h0FF; words[3] = 9'h100;
        start_hi_a = 0;
        load_a(4, 1'b1);
        checks++;
        if (len_a !== 11'd4 || err_a !== 1'b0) begin
            errors++; $display("FAIL gap_prog_len: len=%0d err=%b want 4/0", len_a, err_a);
        end
        wait_start_fall_a(ok);
        checks++;
        if (!ok || start_hi_a !== 2) begin
            errors++; $display("FAIL gap_start: fell=%0b high=%0d want 1/2", ok, start_hi_a);
        end
        check_writes_a("gap");
    endtask

    task automatic test_reset_mid_run();
        repeat (5) tick();
        checks++;
        if (busy_a !== 1'b1 || run_a !== 16'd5) begin
            errors++; $display("FAIL pre_reset_run: busy=%b run=%0d want 1/5", busy_a, run_a);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({if_a.in_ready, if_a.imem_we, start_a, busy_a, done_a, err_a} !== 6'b0
            || {if_a.imem_waddr, if_a.imem_wdata, len_a, run_a} !== 46'b0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b waddr=%0d wdata=%h len=%0d run=%0d want all 0",
                     busy_a, if_a.imem_waddr, if_a.imem_wdata, len_a, run_a);
        end
        #1 rst_n = 1'b1;
        tick();
        checks++;
        if ({if_a.in_ready, busy_a} !== 2'b00) begin
            errors++; $display("FAIL post_reset_idle: rdy=%b busy=%b want 0/0", if_a.in_ready, busy_a);
        end
        load_req_a = 1'b1;
        tick();
        load_req_a = 1'b0;
        checks++;
        if ({if_a.in_ready, busy_a} !== 2'b11 || len_a !== 11'd0) begin
            errors++;
            $display("FAIL post_reset_load: rdy=%b busy=%b len=%0d want 1/1/0",
                     if_a.in_ready, busy_a, len_a);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        for (int i = 0; i < 8; i++) words[i] = 9'h1C0 | 9'(i);
        start_hi_b = 0;
        load_b(8, 1'b0);
        checks++;
        if ({if_b.imem_we, err_b, if_b.in_ready, busy_b} !== 4'b1100 || if_b.imem_waddr !== 3'd7
            || if_b.imem_wdata !== 9'h1C7 || len_b !== 4'd8) begin
            errors++;
            $display("FAIL ovf_last_write: we=%b err=%b rdy=%b busy=%b addr=%0d data=%h len=%0d want 1/1/0/0/7/1c7/8",
                     if_b.imem_we, err_b, if_b.in_ready, busy_b, if_b.imem_waddr,
                     if_b.imem_wdata, len_b);
        end
        repeat (6) tick();
        checks++;
        if (start_hi_b !== 0 || err_b !== 1'b1 || wr_addr_b.size() !== 8) begin
            errors++;
            $display("FAIL ovf_no_start: start_hi=%0d err=%b writes=%0d want 0/1/8",
                     start_hi_b, err_b, wr_addr_b.size());
        end
        load_b(8, 1'b1);
        checks++;
        if (err_b !== 1'b0 || len_b !== 4'd8 || if_b.imem_waddr !== 3'd7 || if_b.imem_we !== 1'b1) begin
            errors++;
            $display("FAIL full_prog: err=%b len=%0d addr=%0d we=%b want 0/8/7/1",
                     err_b, len_b, if_b.imem_waddr, if_b.imem_we);
        end
        wait_start_fall_b(ok);
        checks++;
        if (!ok || start_hi_b !== 2 || err_b !== 1'b0) begin
            errors++;
            $display("FAIL full_prog_start: fell=%0b high=%0d err=%b want 1/2/0", ok, start_hi_b, err_b);
        end
    endtask

    task automatic test_saturate();
        halt_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            load_req_b = (i == 10 || i == 11);
            tick();
        end
        load_req_b = 1'b0;
        checks++;
        if ({busy_b, if_b.in_ready, done_b} !== 3'b100 || len_b !== 4'd8 || run_b !== 4'd15) begin
            errors++;
            $display("FAIL sat_run: busy=%b rdy=%b done=%b len=%0d run=%0d want 1/0/0/8/15",
                     busy_b, if_b.in_ready, done_b, len_b, run_b);
        end
        halt_b = 1'b1;
        tick();
        checks++;
        if (done_b !== 1'b1 || busy_b !== 1'b0 || run_b !== 4'd15) begin
            errors++;
            $display("FAIL sat_halt: done=%b busy=%b run=%0d want 1/0/15", done_b, busy_b, run_b);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_run_count();
        test_gapped();
        test_reset_mid_run();
        test_overflow();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
